pss_correlator_multi_mr: RTL and testbench
==========================================

Name: pss_correlator_multi_mr

Overview:
Time-multiplexed PSS correlator that correlates one complex sample stream against N_SEQ local PSS sequences, such as the three N_ID_2 candidates, using a shared bank of REQ_MULTS = ceil(PSS_LEN/MULT_REUSE) complex MACs. It adds input backpressure (s_axis_in_tready), serial per-sequence evaluation, and tagged outputs (sequence id, last flag). It sits between the decimated sample stream and the PSS peak detector.

Parameters:
IN_DW, 32, input sample width; imag in upper half, real in lower half, each signed IN_DW/2.
OUT_DW, 24, output magnitude width.
TAP_DW, 32, tap width; imag in upper half, real in lower half, each signed TAP_DW/2.
PSS_LEN, 128, taps per sequence.
N_SEQ, 3, number of local sequences (>=1).
MULT_REUSE, 4, MAC cycles per sequence (>=1). PSS_LEN need not divide evenly by it.
PSS_LOCAL, all zeros, N_SEQ*PSS_LEN*TAP_DW bits. Tap k of sequence s is at bit offset (s*PSS_LEN+k)*TAP_DW. Taps are pre-conjugated.

Ports:
clk_i  in  1  clock
reset_ni  in  1  reset, asynchronous, active-low
s_axis_in_tdata  in  IN_DW  complex input sample
s_axis_in_tvalid  in  1  input valid
s_axis_in_tready  out  1  high only in IDLE
m_axis_out_tdata  out  OUT_DW  |corr|^2, truncated
m_axis_out_tuser  out  max(1,$clog2(N_SEQ))  sequence index of current result
m_axis_out_tlast  out  1  high with result of sequence N_SEQ-1
m_axis_out_tvalid  out  1  one-cycle result strobe; no output backpressure

Behaviour:
- Widths:
  - REQ_OUT_DW = IN_DW+TAP_DW+2+2*$clog2(PSS_LEN)+1.
  - Accumulators and sums are signed, REQ_OUT_DW/2+1 bits.
  - mag = re^2+im^2, REQ_OUT_DW bits.
  - tdata = mag[REQ_OUT_DW-2 -: OUT_DW].
- Shift register: PSS_LEN complex entries, entry 0 is newest.
  - Shifts only on accept (tvalid && tready).
  - Zero after reset.
- FSM states: IDLE, MAC, REDUCE, MAG. Counters are seq (0..N_SEQ-1) and idx (0..MULT_REUSE-1).
  - IDLE: tready=1. On accept: shift, clear accumulators, seq=0, idx=0, go to MAC.
  - MAC: each edge, MAC m adds in[p]*tap[seq][p], with p = m*MULT_REUSE+idx.
    - p >= PSS_LEN contributes 0.
    - After idx = MULT_REUSE-1, go to REDUCE.
    - Complex product: re = ar*br - ai*bi, im = ar*bi + ai*br.
  - REDUCE: register the sum of the REQ_MULTS accumulators (re and im), go to MAG.
  - MAG: register tdata=mag, tuser=seq, tlast=(seq==N_SEQ-1), tvalid=1 for exactly one cycle. Clear accumulators and idx.
    - If seq < N_SEQ-1: seq++, go to MAC.
    - Else: go to IDLE.
- Timing:
  - Accept on edge E0. Result for seq s is valid in the cycle after edge E0+(s+1)*(MULT_REUSE+2).
  - Next accept is no earlier than E0+N_SEQ*(MULT_REUSE+2)+1, so the minimum sample period is N_SEQ*(MULT_REUSE+2)+1 cycles (19 at defaults).
- When tvalid=0: tdata, tuser and tlast are 0.
- Input rules:
  - tvalid held while tready=0 is ignored; the sample stays pending upstream.
  - tvalid low in IDLE: stay in IDLE, no shift.
- Reset (asynchronous assertion, any state including mid-MAC): state=IDLE; all outputs 0; tready=0 while reset is asserted; shift register and accumulators zeroed. The in-flight correlation is dropped with no partial output. tready=1 on the first cycle after release.
- Arithmetic wraps at accumulator width; no saturation. Widths are sized so overflow cannot occur for full-scale inputs.

Test Plan:
Common config: IN_DW=16, TAP_DW=16, PSS_LEN=8, N_SEQ=3, MULT_REUSE=3, OUT_DW=40, so tdata = mag[39:0] and the period is 16 cycles. Sequence s taps are all (s+1, 0) unless stated otherwise.
1. Single sample (2,0) after reset -> three strobes 5, 10 and 15 cycles after accept; tdata 4, 16, 36; tuser 0, 1, 2; tlast only on the third.
2. Eight accepted samples (2,0) -> results after the 8th accept are 256, 1024, 2304. Checks the uneven 3/3/2 MAC split.
3. Sequence 0 tap 0 = (0,1), others zero; single input (3,4) -> sequence 0 tdata = 25, i.e. product -4+3j, checking signed complex math.
4. tvalid held high for 100 cycles -> tready high 1 cycle in every 16; exactly 7 accepts; 21 strobes in tuser order 0,1,2 repeating.
5. Reset asserted asynchronously during MAC of seq 1 -> tvalid drops immediately; no seq 1/2 results; after release, single (2,0) -> 4, 16, 36, proving the shift register was cleared.
6. tvalid low for 50 cycles in IDLE -> no strobes; tready stays 1; shift register unchanged, so the next results equal a continuation of the prior sample history.

Source files
------------

// File: rtl/pss_correlator_multi_mr.sv
// Time-multiplexed PSS correlator: one sample stream against N_SEQ local sequences,
// evaluated serially on a shared bank of complex MACs, with tagged |corr|^2 results.
module pss_correlator_multi_mr #(
  parameter int IN_DW      = 32,
  parameter int OUT_DW     = 24,
  parameter int TAP_DW     = 32,
  parameter int PSS_LEN    = 128,
  parameter int N_SEQ      = 3,
  parameter int MULT_REUSE = 4,
  parameter logic [N_SEQ*PSS_LEN*TAP_DW-1:0] PSS_LOCAL = '0,
  localparam int SEQ_W = (N_SEQ > 1) ? $clog2(N_SEQ) : 1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [IN_DW-1:0]  s_axis_in_tdata,
  input  logic              s_axis_in_tvalid,
  output logic              s_axis_in_tready,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic [SEQ_W-1:0]  m_axis_out_tuser,
  output logic              m_axis_out_tlast,
  output logic              m_axis_out_tvalid
);

  localparam int REQ_MULTS  = (PSS_LEN + MULT_REUSE - 1) / MULT_REUSE;
  localparam int REQ_OUT_DW = IN_DW + TAP_DW + 2 + 2 * $clog2(PSS_LEN) + 1;
  localparam int ACC_W      = REQ_OUT_DW / 2 + 1;
  localparam int IH         = IN_DW / 2;
  localparam int TH         = TAP_DW / 2;
  localparam int IDX_W      = (MULT_REUSE > 1) ? $clog2(MULT_REUSE) : 1;
  localparam int SR_AW      = (PSS_LEN > 1) ? $clog2(PSS_LEN) : 1;

  typedef enum logic [1:0] {IDLE, MAC, REDUCE, MAG} state_e;

  state_e                  state_q, state_d;
  logic [SEQ_W-1:0]        seq_q, seq_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IN_DW-1:0]        sr_q [PSS_LEN];
  logic [IN_DW-1:0]        sr_d [PSS_LEN];
  logic signed [ACC_W-1:0] acc_re_q [REQ_MULTS];
  logic signed [ACC_W-1:0] acc_re_d [REQ_MULTS];
  logic signed [ACC_W-1:0] acc_im_q [REQ_MULTS];
  logic signed [ACC_W-1:0] acc_im_d [REQ_MULTS];
  logic signed [ACC_W-1:0] prod_re [REQ_MULTS];
  logic signed [ACC_W-1:0] prod_im [REQ_MULTS];
  logic signed [ACC_W-1:0] sum_re_q, sum_re_d;
  logic signed [ACC_W-1:0] sum_im_q, sum_im_d;
  logic signed [REQ_OUT_DW-1:0] re_x, im_x;
  logic [REQ_OUT_DW-1:0]   mag;
  logic                    unused_mag;
  logic [OUT_DW-1:0]       out_data_q, out_data_d;
  logic [SEQ_W-1:0]        out_user_q, out_user_d;
  logic                    out_last_q, out_last_d;
  logic                    out_valid_q, out_valid_d;
  logic                    accept, seq_last, idx_last;

  assign accept   = s_axis_in_tvalid && s_axis_in_tready;
  assign seq_last = (seq_q == SEQ_W'(N_SEQ - 1));
  assign idx_last = (idx_q == IDX_W'(MULT_REUSE - 1));

  // MAC m serves tap p = m*MULT_REUSE+idx; taps past PSS_LEN read as zero.
  for (genvar m = 0; m < REQ_MULTS; m++) begin : g_mac
    int                      p;
    logic [IN_DW-1:0]        smp;
    logic [TAP_DW-1:0]       tap;
    logic signed [ACC_W-1:0] ar, ai, br, bi;

    always_comb begin
      p   = m * MULT_REUSE + int'(idx_q);
      smp = '0;
      tap = '0;
      if (p < PSS_LEN) begin
        smp = sr_q[SR_AW'(p)];
        tap = PSS_LOCAL[(int'(seq_q) * PSS_LEN + p) * TAP_DW +: TAP_DW];
      end
    end

    assign ar = ACC_W'($signed(smp[IH-1:0]));
    assign ai = ACC_W'($signed(smp[IN_DW-1 -: IH]));
    assign br = ACC_W'($signed(tap[TH-1:0]));
    assign bi = ACC_W'($signed(tap[TAP_DW-1 -: TH]));
    assign prod_re[m] = ar * br - ai * bi;
    assign prod_im[m] = ar * bi + ai * br;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = MAC;
      MAC:     if (idx_last) state_d = REDUCE;
      REDUCE:  state_d = MAG;
      MAG:     state_d = seq_last ? IDLE : MAC;
      default: state_d = IDLE;
    endcase
  end

  // Ready is forced low while reset is held, even though the state already reads IDLE.
  always_comb begin
    s_axis_in_tready = reset_ni && (state_q == IDLE);
  end

  always_comb begin
    sr_d     = sr_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    seq_d    = seq_q;
    idx_d    = idx_q;
    sum_re_d = sum_re_q;
    sum_im_d = sum_im_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sr_d[0] = s_axis_in_tdata;
          for (int i = 1; i < PSS_LEN; i++) sr_d[i] = sr_q[i-1];
          for (int m = 0; m < REQ_MULTS; m++) begin
            acc_re_d[m] = '0;
            acc_im_d[m] = '0;
          end
          seq_d = '0;
          idx_d = '0;
        end
      end
      MAC: begin
        for (int m = 0; m < REQ_MULTS; m++) begin
          acc_re_d[m] = acc_re_q[m] + prod_re[m];
          acc_im_d[m] = acc_im_q[m] + prod_im[m];
        end
        if (!idx_last) idx_d = idx_q + IDX_W'(1);
      end
      REDUCE: begin
        sum_re_d = '0;
        sum_im_d = '0;
        for (int m = 0; m < REQ_MULTS; m++) begin
          sum_re_d = sum_re_d + acc_re_q[m];
          sum_im_d = sum_im_d + acc_im_q[m];
        end
      end
      MAG: begin
        for (int m = 0; m < REQ_MULTS; m++) begin
          acc_re_d[m] = '0;
          acc_im_d[m] = '0;
        end
        idx_d = '0;
        seq_d = seq_last ? '0 : seq_q + SEQ_W'(1);
      end
      default: ;
    endcase
  end

  assign re_x       = REQ_OUT_DW'(sum_re_q);
  assign im_x       = REQ_OUT_DW'(sum_im_q);
  assign mag        = REQ_OUT_DW'(re_x * re_x + im_x * im_x);
  assign unused_mag = ^mag;

  // Result registers are zero in every cycle that is not a strobe.
  always_comb begin
    out_data_d  = '0;
    out_user_d  = '0;
    out_last_d  = 1'b0;
    out_valid_d = 1'b0;
    if (state_q == MAG) begin
      out_data_d  = mag[REQ_OUT_DW-2 -: OUT_DW];
      out_user_d  = seq_q;
      out_last_d  = seq_last;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < PSS_LEN; i++) sr_q[i] <= '0;
      for (int m = 0; m < REQ_MULTS; m++) begin
        acc_re_q[m] <= '0;
        acc_im_q[m] <= '0;
      end
      seq_q       <= '0;
      idx_q       <= '0;
      sum_re_q    <= '0;
      sum_im_q    <= '0;
      out_data_q  <= '0;
      out_user_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      acc_re_q    <= acc_re_d;
      acc_im_q    <= acc_im_d;
      seq_q       <= seq_d;
      idx_q       <= idx_d;
      sum_re_q    <= sum_re_d;
      sum_im_q    <= sum_im_d;
      out_data_q  <= out_data_d;
      out_user_q  <= out_user_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign m_axis_out_tdata  = out_data_q;
  assign m_axis_out_tuser  = out_user_q;
  assign m_axis_out_tlast  = out_last_q;
  assign m_axis_out_tvalid = out_valid_q;

endmodule

// File: tb/tb_pss_correlator_multi_mr.sv
// Scoreboard bench for pss_correlator_multi_mr: directed samples push expected
// strobes into per-DUT queues; monitors pop and compare on every valid strobe.
module tb_pss_correlator_multi_mr;

  localparam int IN_DW = 16, TAP_DW = 16, PSS_LEN = 8, N_SEQ = 3, MULT_REUSE = 3, OUT_DW = 40;
  localparam logic [N_SEQ*PSS_LEN*TAP_DW-1:0] TAPS_A = {{8{16'h0003}}, {8{16'h0002}}, {8{16'h0001}}};
  localparam logic [N_SEQ*PSS_LEN*TAP_DW-1:0] TAPS_B = {368'b0, 16'h0100};

  typedef struct packed {
    logic [39:0] data;
    logic [1:0]  user;
    logic        last;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] a_tdata = '0, b_tdata = '0;
  logic        a_tvalid = 1'b0, b_tvalid = 1'b0;
  logic        a_tready, b_tready;
  logic [39:0] a_odata, b_odata;
  logic [1:0]  a_ouser, b_ouser;
  logic        a_olast, b_olast, a_ovalid, b_ovalid;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   fail_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pss_correlator_multi_mr #(
    .IN_DW(IN_DW), .OUT_DW(OUT_DW), .TAP_DW(TAP_DW), .PSS_LEN(PSS_LEN),
    .N_SEQ(N_SEQ), .MULT_REUSE(MULT_REUSE), .PSS_LOCAL(TAPS_A)
  ) dut_a (
    .clk_i(clk), .reset_ni(reset_n),
    .s_axis_in_tdata(a_tdata), .s_axis_in_tvalid(a_tvalid), .s_axis_in_tready(a_tready),
    .m_axis_out_tdata(a_odata), .m_axis_out_tuser(a_ouser),
    .m_axis_out_tlast(a_olast), .m_axis_out_tvalid(a_ovalid)
  );

  pss_correlator_multi_mr #(
    .IN_DW(IN_DW), .OUT_DW(OUT_DW), .TAP_DW(TAP_DW), .PSS_LEN(PSS_LEN),
    .N_SEQ(N_SEQ), .MULT_REUSE(MULT_REUSE), .PSS_LOCAL(TAPS_B)
  ) dut_b (
    .clk_i(clk), .reset_ni(reset_n),
    .s_axis_in_tdata(b_tdata), .s_axis_in_tvalid(b_tvalid), .s_axis_in_tready(b_tready),
    .m_axis_out_tdata(b_odata), .m_axis_out_tuser(b_ouser),
    .m_axis_out_tlast(b_olast), .m_axis_out_tvalid(b_ovalid)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input bit sel, input logic [39:0] data, input int s, input int e0);
    exp_t e;
    e.data = data;
    e.user = 2'(s);
    e.last = (s == N_SEQ - 1);
    e.cyc  = 32'(e0 + (s + 1) * (MULT_REUSE + 2));
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
  endtask

  // Offers one sample, waits (bounded) for acceptance, then queues n_exp expected results.
  task automatic apply_stimulus(input bit sel, input logic [15:0] data, input int n_exp,
                                input logic [39:0] e0v, input logic [39:0] e1v, input logic [39:0] e2v);
    int n = 0;
    int e0;
    @(negedge clk);
    if (sel) begin b_tdata = data; b_tvalid = 1'b1; end
    else     begin a_tdata = data; a_tvalid = 1'b1; end
    while (!(sel ? b_tready : a_tready) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      check_output("accept_timeout", 64'(n), 0);
      a_tvalid = 1'b0;
      b_tvalid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      e0 = cyc;
      a_tvalid = 1'b0;
      b_tvalid = 1'b0;
      for (int s = 0; s < n_exp; s++)
        push_exp(sel, (s == 0) ? e0v : (s == 1) ? e1v : e2v, s, e0);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("drain", 64'(qa.size() + qb.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2 reset_n = 1'b0;
    #1;
    check_output("tready_in_reset_a", 64'(a_tready), 0);
    check_output("tready_in_reset_b", 64'(b_tready), 0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    #1;
    check_output("tready_after_release", 64'(a_tready), 1);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (a_ovalid) begin
      check_output("a_strobe_expected", 64'(qa.size() != 0), 1);
      if (qa.size() != 0) begin
        exp_t e;
        e = qa.pop_front();
        check_output("a_tdata", 64'(a_odata), 64'(e.data));
        check_output("a_tuser", 64'(a_ouser), 64'(e.user));
        check_output("a_tlast", 64'(a_olast), 64'(e.last));
        check_output("a_latency", 64'(cyc), 64'(e.cyc));
      end
    end else begin
      check_output("a_idle_zero", {21'b0, a_odata, a_ouser, a_olast}, 0);
    end
  end

  always @(negedge clk) begin
    if (b_ovalid) begin
      check_output("b_strobe_expected", 64'(qb.size() != 0), 1);
      if (qb.size() != 0) begin
        exp_t e;
        e = qb.pop_front();
        check_output("b_tdata", 64'(b_odata), 64'(e.data));
        check_output("b_tuser", 64'(b_ouser), 64'(e.user));
        check_output("b_tlast", 64'(b_olast), 64'(e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc_n;
    int last_i;
    int low_cnt;
    logic [39:0] v;

    #2;
    check_output("tready_at_reset", 64'(a_tready), 0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    #1;
    check_output("tready_after_reset", 64'(a_tready), 1);

    // Single (2,0): 4, 16, 36 at 5/10/15 cycles
    apply_stimulus(0, 16'h0002, 3, 40'd4, 40'd16, 40'd36);
    wait_drain();

    // Fill the shift register with (2,0); after k accepts |sum| = 2k(s+1)
    for (int k = 2; k <= 8; k++)
      apply_stimulus(0, 16'h0002, 3, 40'((2*k)*(2*k)), 40'((4*k)*(4*k)), 40'((6*k)*(6*k)));
    wait_drain();

    // History [1,2x7] -> sum 15(s+1)
    apply_stimulus(0, 16'h0001, 3, 40'd225, 40'd900, 40'd2025);
    wait_drain();

    // Idle with junk on tdata: no shift, tready stays high
    a_tdata = 16'h0005;
    low_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!a_tready) low_cnt++;
    end
    check_output("idle_tready_low_cycles", 64'(low_cnt), 0);
    // History [0,1,2x6] -> sum 13(s+1)
    apply_stimulus(0, 16'h0000, 3, 40'd169, 40'd676, 40'd1521);
    wait_drain();

    // Signed complex math on the second instance: (3,4)*(0,1) = -4+3j
    apply_stimulus(1, 16'h0403, 3, 40'd25, 40'd0, 40'd0);
    // (-1,2)*(0,1) = -2-1j
    apply_stimulus(1, 16'h02FF, 3, 40'd5, 40'd0, 40'd0);
    wait_drain();

    // Continuous tvalid for 100 cycles from a cleared history of (1,0) samples
    pulse_reset();
    a_tdata  = 16'h0001;
    a_tvalid = 1'b1;
    acc_n    = 0;
    last_i   = -1;
    for (int i = 0; i < 100; i++) begin
      if (a_tready) begin
        acc_n++;
        if (last_i >= 0) check_output("stream_accept_gap", 64'(i - last_i), 16);
        last_i = i;
        for (int s = 0; s < N_SEQ; s++) begin
          v = 40'((acc_n * (s + 1)) * (acc_n * (s + 1)));
          push_exp(0, v, s, cyc + 1);
        end
      end
      @(negedge clk);
    end
    a_tvalid = 1'b0;
    check_output("stream_accepts", 64'(acc_n), 7);
    wait_drain();

    // Reset mid-MAC of seq 1: only seq 0 result survives, history is cleared
    pulse_reset();
    apply_stimulus(0, 16'h0002, 1, 40'd4, 40'd0, 40'd0);
    repeat (7) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check_output("midmac_reset_tvalid", 64'(a_ovalid), 0);
    check_output("midmac_reset_tready", 64'(a_tready), 0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    #1;
    check_output("midmac_release_tready", 64'(a_tready), 1);
    repeat (30) @(negedge clk);
    check_output("midmac_no_late_results", 64'(qa.size()), 0);
    apply_stimulus(0, 16'h0002, 3, 40'd4, 40'd16, 40'd36);
    wait_drain();

    $display("[TB] %0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule
